// File: rtl/exe_issue_ctrl_pkg.sv
// Shared types and default sizing for the Execute issue controller and its
// per-register scoreboard counters.
package exe_issue_ctrl_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_MAX_LAT  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } IssueState_t;

endpackage

// File: rtl/exe_sb_counter.sv
// One scoreboard entry: cycles remaining until the pending write to this
// register lands. A new set overrides the running countdown.
module exe_sb_counter
    import exe_issue_ctrl_pkg::*;
#(
    parameter int LAT_W = $clog2(DEF_MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [LAT_W-1:0] set_val,
    output logic [LAT_W-1:0] cnt,
    output logic             busy,
    output logic             near_free
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (set) begin
            cnt_d = set_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign busy      = (cnt_q != '0);
    assign near_free = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/exe_issue_ctrl.sv
// Decode->Execute issue controller: per-register write scoreboard, RAW/WAW
// stalls and drain-before-serialize. Define EXE_ISSUE_BYPASS_EN for forwarding.
module exe_issue_ctrl
    import exe_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_ID_W = $clog2(NUM_REGS),
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_ID_W-1:0] in_rs1,
    input  logic                in_rs1_used,
    input  logic [REG_ID_W-1:0] in_rs2,
    input  logic                in_rs2_used,
    input  logic [REG_ID_W-1:0] in_rd,
    input  logic                in_rd_wr,
    input  logic [LAT_W-1:0]    in_lat,
    input  logic                in_serial,
    input  logic                flush,
    output logic                exe_issue,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic [31:0]         stall_cnt
);

`ifdef EXE_ISSUE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);

    // The count holds cycles until the result lands, so latency L loads L-1:
    // a dependent of a producer issued at T sees the register free at T+L.
    function automatic logic [LAT_W-1:0] load_val(input logic [LAT_W-1:0] lat);
        if (lat == '0) begin
            return '0;
        end else if (lat > LAT_MAX_V) begin
            return LAT_MAX_V - LAT_W'(1);
        end else begin
            return lat - LAT_W'(1);
        end
    endfunction

    IssueState_t         state_q, state_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] near_free;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] blocked;
    logic [LAT_W-1:0]    set_val;
    logic                sb_empty;
    logic                hazard;
    logic                rdy;

    assign set_val = load_val(in_lat);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign set_vec[r] = exe_issue & in_rd_wr & (in_rd != '0) & (in_rd == REG_ID_W'(r));

        exe_sb_counter #(
            .LAT_W(LAT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .set      (set_vec[r]),
            .set_val  (set_val),
            .cnt      (cnt[r]),
            .busy     (sb_busy[r]),
            .near_free(near_free[r])
        );

        // With forwarding, a result in its final cycle no longer blocks readers.
        assign blocked[r] = (r != 0) && sb_busy[r] && !(BYPASS_EN && near_free[r]);
    end

    always_comb begin
        sb_empty = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt[r] != '0) begin
                sb_empty = 1'b0;
            end
        end
    end

    assign hazard = (in_rs1_used & blocked[in_rs1])
                  | (in_rs2_used & blocked[in_rs2])
                  | (in_rd_wr    & blocked[in_rd]);

    assign rdy = in_valid & ~flush & (state_q != DRAIN) & ~hazard
               & (~in_serial | sb_empty);

    assign in_ready  = rdy;
    assign exe_issue = in_valid & rdy;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (in_valid && !flush) begin
                    if (in_serial && !sb_empty) begin
                        state_d = DRAIN;
                    end else if (hazard && !in_serial) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (flush || exe_issue) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (flush || sb_empty) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (in_valid && !rdy && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Table-driven bench for exe_issue_ctrl; expected values per cycle are queued
// when a row is driven and compared when the outputs settle mid-cycle.
module tb_exe_issue_ctrl;

    localparam int NUM_REGS = 32;
    localparam int REG_ID_W = 5;
    localparam int MAX_LAT  = 4;
    localparam int LAT_W    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [REG_ID_W-1:0] in_rs1;
    logic                in_rs1_used;
    logic [REG_ID_W-1:0] in_rs2;
    logic                in_rs2_used;
    logic [REG_ID_W-1:0] in_rd;
    logic                in_rd_wr;
    logic [LAT_W-1:0]    in_lat;
    logic                in_serial;
    logic                flush;
    logic                exe_issue;
    logic [NUM_REGS-1:0] sb_busy;
    logic [31:0]         stall_cnt;

    always #5 clk = ~clk;

    exe_issue_ctrl #(
        .NUM_REGS(NUM_REGS),
        .REG_ID_W(REG_ID_W),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs1_used(in_rs1_used),
        .in_rs2     (in_rs2),
        .in_rs2_used(in_rs2_used),
        .in_rd      (in_rd),
        .in_rd_wr   (in_rd_wr),
        .in_lat     (in_lat),
        .in_serial  (in_serial),
        .flush      (flush),
        .exe_issue  (exe_issue),
        .sb_busy    (sb_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic                v;
        logic [REG_ID_W-1:0] rs1;
        logic                u1;
        logic [REG_ID_W-1:0] rs2;
        logic                u2;
        logic [REG_ID_W-1:0] rd;
        logic                wr;
        logic [LAT_W-1:0]    lat;
        logic                ser;
        logic                fl;
        logic                exp_rdy;
        logic [31:0]         exp_busy;
        logic [31:0]         exp_stall;
    } vec_t;

    typedef struct {
        logic        rdy;
        logic [31:0] busy;
        logic [31:0] stall;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          passed = 0;
    logic [31:0] run_stall = '0;

    function automatic logic [31:0] bit_of(input int r);
        return 32'(1) << r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Stall expectation follows from the expected ready of the earlier rows.
    task automatic add(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input int lat, input bit ser, input bit fl,
                       input bit rdy, input logic [31:0] busy);
        vec_t t;
        t.v = v;   t.rs1 = REG_ID_W'(rs1); t.u1 = u1;
        t.rs2 = REG_ID_W'(rs2); t.u2 = u2;
        t.rd = REG_ID_W'(rd);   t.wr = wr;  t.lat = LAT_W'(lat);
        t.ser = ser; t.fl = fl;
        t.exp_rdy = rdy; t.exp_busy = busy; t.exp_stall = run_stall;
        if (v && !rdy && !fl) run_stall = run_stall + 32'd1;
        tbl.push_back(t);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rs1 = '0; in_rs1_used = 1'b0; in_rs2 = '0; in_rs2_used = 1'b0;
        in_rd = '0; in_rd_wr = 1'b0; in_lat = '0; in_serial = 1'b0; flush = 1'b0;
    endtask

    task automatic drive(input vec_t t);
        in_valid = t.v; in_rs1 = t.rs1; in_rs1_used = t.u1; in_rs2 = t.rs2; in_rs2_used = t.u2;
        in_rd = t.rd; in_rd_wr = t.wr; in_lat = t.lat; in_serial = t.ser; flush = t.fl;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        idle_inputs();

        // RAW on r5, latency 3
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, 32'd0);
        add(1, 0,0, 0,0, 5,1,3, 0,0, 1, 32'd0);
        add(1, 5,1, 0,0, 0,0,0, 0,0, 0, bit_of(5));
`ifdef EXE_ISSUE_BYPASS_EN
        add(1, 5,1, 0,0, 0,0,0, 0,0, 1, bit_of(5));
`else
        add(1, 5,1, 0,0, 0,0,0, 0,0, 0, bit_of(5));
        add(1, 5,1, 0,0, 0,0,0, 0,0, 1, 32'd0);
`endif
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, 32'd0);
        // latency 1 and latency 0 (treated as 1) issue back to back
        add(1, 0,0, 0,0, 10,1,1, 0,0, 1, 32'd0);
        add(1, 10,1, 0,0, 11,1,0, 0,0, 1, 32'd0);
        add(1, 0,0, 11,1, 0,0,0, 0,0, 1, 32'd0);
        // r0 is never tracked
        add(1, 0,0, 0,0, 0,1,4, 0,0, 1, 32'd0);
        add(1, 0,1, 0,1, 0,1,4, 0,0, 1, 32'd0);
        // flushed write must not mark r13
        add(1, 0,0, 0,0, 13,1,4, 0,1, 0, 32'd0);
        add(1, 13,1, 0,0, 0,0,0, 0,0, 1, 32'd0);
        // serial instruction drains r7 first
        add(1, 0,0, 0,0, 7,1,4, 0,0, 1, 32'd0);
        add(1, 0,0, 0,0, 0,0,0, 1,0, 0, bit_of(7));
        add(1, 0,0, 0,0, 0,0,0, 1,0, 0, bit_of(7));
        add(1, 0,0, 0,0, 0,0,0, 1,0, 0, bit_of(7));
        add(1, 0,0, 0,0, 0,0,0, 1,0, 0, 32'd0);
        add(1, 0,0, 0,0, 0,0,0, 1,0, 1, 32'd0);
        // flush while stalled on r3; r3 keeps counting down
        add(1, 0,0, 0,0, 3,1,4, 0,0, 1, 32'd0);
        add(1, 3,1, 0,0, 0,0,0, 0,0, 0, bit_of(3));
        add(1, 3,1, 0,0, 0,0,0, 0,1, 0, bit_of(3));
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, bit_of(3));
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, 32'd0);
        // WAW on r9, reload with latency 4
        add(1, 0,0, 0,0, 9,1,2, 0,0, 1, 32'd0);
`ifdef EXE_ISSUE_BYPASS_EN
        add(1, 0,0, 0,0, 9,1,4, 0,0, 1, bit_of(9));
`else
        add(1, 0,0, 0,0, 9,1,4, 0,0, 0, bit_of(9));
        add(1, 0,0, 0,0, 9,1,4, 0,0, 1, 32'd0);
`endif
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, bit_of(9));
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, bit_of(9));
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, bit_of(9));
        add(0, 0,0, 0,0, 0,0,0, 0,0, 0, 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", sb_busy, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            exp_q.push_back('{tbl[i].exp_rdy, tbl[i].exp_busy, tbl[i].exp_stall});
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL row%0d_queue: got empty queue, expected an entry", i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("row%0d_ready", i), {31'd0, in_ready}, {31'd0, e.rdy});
                check($sformatf("row%0d_issue", i), {31'd0, exe_issue}, {31'd0, e.rdy});
                check($sformatf("row%0d_busy", i), sb_busy, e.busy);
                check($sformatf("row%0d_stall_cnt", i), stall_cnt, e.stall);
            end
        end

        // Reset while r12 is in flight
        @(posedge clk);
        #1;
        idle_inputs();
        in_valid = 1'b1; in_rd = 5'd12; in_rd_wr = 1'b1; in_lat = 3'd4;
        @(negedge clk);
        check("rstmid_issue", {31'd0, exe_issue}, 32'd1);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check("rstmid_busy_before", sb_busy, bit_of(12));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy_after", sb_busy, 32'd0);
        check("rstmid_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_rs1 = 5'd12; in_rs1_used = 1'b1;
        @(negedge clk);
        check("rstmid_dep_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
